qif_neuron_array: RTL

Parametrised, time-multiplexed quadratic integrate-and-fire (QIF) neuron array. Holds the membrane state for `N_CH` channels. Accepts one synaptic-current sample per cycle over a valid/ready handshake and applies the QIF update to the addressed channel. Emits the new membrane voltage and a spike flag with one cycle of latency. It is the multi-channel, threshold/reset/refractory-capable successor to the single 8-bit QIF cell in the neuron datapath.

---
 rtl/qif_neuron_array_pkg.sv | 28 ++
 rtl/qif_neuron_array_if.sv | 28 ++
 rtl/qif_neuron_array_update.sv | 49 ++++
 rtl/qif_neuron_array.sv | 91 +++++++++
 4 files changed

// File: rtl/qif_neuron_array_pkg.sv
// Shared defaults and helpers for the QIF neuron array: parameter defaults,
// the index-width helper and the wide-to-narrow signed saturation function.
package qif_pkg;

  localparam int QIF_WIDTH   = 8;
  localparam int QIF_N_CH    = 4;
  localparam int QIF_V_TH    = 50;
  localparam int QIF_V_RESET = -20;
  localparam int QIF_I_SHIFT = 2;
  localparam int QIF_Q_SHIFT = 3;
  localparam int QIF_REFRACT = 2;

  // Bits needed to index n items, never less than one.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic longint sat_signed(input longint x, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/qif_neuron_array_if.sv
// Sample-in / result-out handshake bundle of the QIF neuron array.
// master drives samples and accepts results; slave is the array itself.
interface qif_neuron_array_if
  import qif_pkg::*;
#(
  parameter int WIDTH = QIF_WIDTH,
  parameter int CH_W  = idx_w(QIF_N_CH)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CH_W-1:0]         in_ch;
  logic signed [WIDTH-1:0] in_cur;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH_W-1:0]         out_ch;
  logic signed [WIDTH-1:0] v_mem;
  logic                    spike;

  modport master (
    output in_valid, in_ch, in_cur, out_ready,
    input  in_ready, out_valid, out_ch, v_mem, spike
  );

  modport slave (
    input  in_valid, in_ch, in_cur, out_ready,
    output in_ready, out_valid, out_ch, v_mem, spike
  );
endinterface

// File: rtl/qif_neuron_array_update.sv
// Combinational QIF step for one channel: quadratic integrate, saturate,
// threshold, reset and refractory countdown. Zero latency, no handshake.
module qif_update
  import qif_pkg::*;
#(
  parameter int WIDTH   = QIF_WIDTH,
  parameter int V_TH    = QIF_V_TH,
  parameter int V_RESET = QIF_V_RESET,
  parameter int I_SHIFT = QIF_I_SHIFT,
  parameter int Q_SHIFT = QIF_Q_SHIFT,
  parameter int REFRACT = QIF_REFRACT,
  localparam int RW     = idx_w(REFRACT + 1)
) (
  input  logic signed [WIDTH-1:0] v,
  input  logic [RW-1:0]           refr,
  input  logic signed [WIDTH-1:0] cur,
  output logic signed [WIDTH-1:0] vn,
  output logic [RW-1:0]           refr_n,
  output logic                    spike
);
  localparam int SW = 2 * WIDTH + 2;
  localparam logic signed [WIDTH-1:0] VTH_W  = WIDTH'(V_TH);
  localparam logic signed [WIDTH-1:0] VRST_W = WIDTH'(V_RESET);

  logic signed [WIDTH-1:0] q;
  logic signed [WIDTH-1:0] cur_s;
  logic signed [WIDTH-1:0] vsat;
  logic signed [SW-1:0]    sum;

  assign q     = v >>> Q_SHIFT;
  assign cur_s = cur >>> I_SHIFT;
  // Wide enough that v + cur + q*q can never wrap before saturation.
  assign sum   = SW'(v) + SW'(cur_s) + SW'(q) * SW'(q);
  assign vsat  = WIDTH'(sat_signed(longint'(sum), WIDTH));

  always_comb begin
    spike  = 1'b0;
    vn     = VRST_W;
    refr_n = '0;
    if (refr != '0) begin
      refr_n = refr - RW'(1);
    end else if (vsat >= VTH_W) begin
      spike  = 1'b1;
      refr_n = RW'(REFRACT);
    end else begin
      vn = vsat;
    end
  end
endmodule

// File: rtl/qif_neuron_array.sv
// Time-multiplexed QIF neuron array: one shared update datapath, per-channel state.
// Latency 1; in_ready = !out_valid || out_ready, results held while stalled.
module qif_neuron_array
  import qif_pkg::*;
#(
  parameter int WIDTH   = QIF_WIDTH,
  parameter int N_CH    = QIF_N_CH,
  parameter int V_TH    = QIF_V_TH,
  parameter int V_RESET = QIF_V_RESET,
  parameter int I_SHIFT = QIF_I_SHIFT,
  parameter int Q_SHIFT = QIF_Q_SHIFT,
  parameter int REFRACT = QIF_REFRACT
) (
  input  logic              clk,
  input  logic              rst_n,
  qif_neuron_array_if.slave bus
);
  localparam int CH_W = idx_w(N_CH);
  localparam int RW   = idx_w(REFRACT + 1);
  localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

  logic signed [WIDTH-1:0] v_q    [N_CH];
  logic [RW-1:0]           refr_q [N_CH];

  logic                    out_valid_q;
  logic [CH_W-1:0]         out_ch_q;
  logic signed [WIDTH-1:0] v_mem_q;
  logic                    spike_q;

  logic                    in_ready;
  logic                    xfer;
  logic                    ch_ok;
  logic [CH_W-1:0]         idx;
  logic signed [WIDTH-1:0] vn;
  logic [RW-1:0]           refr_n;
  logic                    spk;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign xfer     = bus.in_valid && in_ready;
  // Out-of-range channels are consumed but must not touch any state.
  assign ch_ok    = {1'b0, bus.in_ch} < N_CH_L;
  assign idx      = ch_ok ? bus.in_ch : '0;

  qif_update #(
    .WIDTH  (WIDTH),
    .V_TH   (V_TH),
    .V_RESET(V_RESET),
    .I_SHIFT(I_SHIFT),
    .Q_SHIFT(Q_SHIFT),
    .REFRACT(REFRACT)
  ) u_update (
    .v     (v_q[idx]),
    .refr  (refr_q[idx]),
    .cur   (bus.in_cur),
    .vn    (vn),
    .refr_n(refr_n),
    .spike (spk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        v_q[i]    <= '0;
        refr_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      v_mem_q     <= '0;
      spike_q     <= 1'b0;
    end else if (xfer) begin
      if (ch_ok) begin
        v_q[idx]    <= vn;
        refr_q[idx] <= refr_n;
        out_valid_q <= 1'b1;
        out_ch_q    <= bus.in_ch;
        v_mem_q     <= vn;
        spike_q     <= spk;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.v_mem     = v_mem_q;
  assign bus.spike     = spike_q;
endmodule
